// File: rtl/alu_sequencer.sv
// Handshaked single-issue front end for the combinational ALU, with a result accumulator.
// Optional result flags (res_zero, res_neg) are enabled by defining ALU_SEQ_FLAGS_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command; cmd_ready high
// S_ISSUE | operands held on alu_*; settle counter running down to 0
// S_RESP  | captured result presented; waiting for res_ready
module alu_sequencer #(
  parameter int WIDTH  = 16,
  parameter int SEL_W  = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             res_zero,
  output logic             res_neg
`endif
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;
  logic [WIDTH-1:0] r_res_data;
  logic [WIDTH-1:0] r_acc;
  logic             w_accept;
  logic             w_capture;
  logic             w_cmd_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_cmd_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_res_data <= '0;
      r_acc      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_alu_a   <= cmd_chain ? r_acc : cmd_a;
        r_alu_b   <= cmd_b;
        r_alu_sel <= cmd_sel;
        r_cnt     <= CNT_LOAD;
      end else if (r_state == S_ISSUE && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Accumulator only ever tracks captured results, so chaining sees the last completed op.
      if (w_capture) begin
        r_res_data <= alu_out;
        r_acc      <= alu_out;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic r_res_zero;
  logic r_res_neg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_zero <= 1'b0;
      r_res_neg  <= 1'b0;
    end else if (w_capture) begin
      r_res_zero <= (alu_out == '0);
      r_res_neg  <= alu_out[WIDTH-1];
    end
  end

  assign res_zero = r_res_zero;
  assign res_neg  = r_res_neg;
`endif

  assign cmd_ready = w_cmd_ready;
  assign res_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: SETTLE=1 and SETTLE=3 instances, each driving an ALU stub.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ALU stub: sel 0 = A+B, sel 1 = A-B, anything else passes A through
  function automatic logic [15:0] alu_stub(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] sel);
    case (sel)
      3'd0:    return a + b;
      3'd1:    return a - b;
      default: return a;
    endcase
  endfunction

  // ---------------- SETTLE=1 instance ----------------
  logic        cmd_valid = 1'b0, cmd_chain = 1'b0, res_ready = 1'b1;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic [2:0]  cmd_sel = '0;
  logic        cmd_ready, res_valid, busy;
  logic [15:0] alu_a, alu_b, alu_out, res_data;
  logic [2:0]  alu_sel;
`ifdef ALU_SEQ_FLAGS_EN
  logic        res_zero, res_neg;
`endif

  assign alu_out = alu_stub(alu_a, alu_b, alu_sel);

  alu_sequencer #(.WIDTH(16), .SEL_W(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
`ifdef ALU_SEQ_FLAGS_EN
    , .res_zero(res_zero), .res_neg(res_neg)
`endif
  );

  // ---------------- SETTLE=3 instance ----------------
  logic        cmd_valid3 = 1'b0, cmd_chain3 = 1'b0, res_ready3 = 1'b1;
  logic [15:0] cmd_a3 = '0, cmd_b3 = '0;
  logic [2:0]  cmd_sel3 = '0;
  logic        cmd_ready3, res_valid3, busy3;
  logic [15:0] alu_a3, alu_b3, alu_out3, res_data3;
  logic [2:0]  alu_sel3;
`ifdef ALU_SEQ_FLAGS_EN
  logic        res_zero3, res_neg3;
`endif

  assign alu_out3 = alu_stub(alu_a3, alu_b3, alu_sel3);

  alu_sequencer #(.WIDTH(16), .SEL_W(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_sel(cmd_sel3), .cmd_chain(cmd_chain3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_out(alu_out3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
    .busy(busy3)
`ifdef ALU_SEQ_FLAGS_EN
    , .res_zero(res_zero3), .res_neg(res_neg3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sel;
    logic        chain;
    logic [15:0] exp_a;
    logic [15:0] exp_res;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs[NVEC];

  // One full command on the SETTLE=1 instance with res_ready held high.
  task automatic run1(input vec_t v, input int idx);
    @(negedge clk);
    cmd_a = v.a; cmd_b = v.b; cmd_sel = v.sel; cmd_chain = v.chain; cmd_valid = 1'b1;
    check($sformatf("v%0d cmd_ready_idle", idx), cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check($sformatf("v%0d alu_a", idx), alu_a, v.exp_a);
    check($sformatf("v%0d alu_b", idx), alu_b, v.b);
    check($sformatf("v%0d alu_sel", idx), alu_sel, v.sel);
    check($sformatf("v%0d busy_issue", idx), busy, 1);
    check($sformatf("v%0d res_valid_early", idx), res_valid, 0);
    @(negedge clk);
    check($sformatf("v%0d res_valid", idx), res_valid, 1);
    check($sformatf("v%0d res_data", idx), res_data, v.exp_res);
`ifdef ALU_SEQ_FLAGS_EN
    check($sformatf("v%0d res_zero", idx), res_zero, (v.exp_res == 16'h0000));
    check($sformatf("v%0d res_neg", idx), res_neg, v.exp_res[15]);
`endif
    @(negedge clk);
    check($sformatf("v%0d res_valid_drop", idx), res_valid, 0);
    check($sformatf("v%0d cmd_ready_after", idx), cmd_ready, 1);
  endtask

  initial begin
    //           a         b         sel   chain  exp_a     exp_res
    vecs[0] = '{16'h0AB0, 16'h01AC, 3'd0, 1'b0, 16'h0AB0, 16'h0C5C};
    vecs[1] = '{16'hBEEF, 16'h0004, 3'd0, 1'b1, 16'h0C5C, 16'h0C60};
    vecs[2] = '{16'h0AB0, 16'h01AC, 3'd1, 1'b0, 16'h0AB0, 16'h0904};
    vecs[3] = '{16'h0000, 16'h0010, 3'd1, 1'b1, 16'h0904, 16'h08F4};
    vecs[4] = '{16'hFFFF, 16'h0002, 3'd0, 1'b0, 16'hFFFF, 16'h0001};
    vecs[5] = '{16'h1234, 16'h5678, 3'd5, 1'b0, 16'h1234, 16'h1234};
    vecs[6] = '{16'hAAAA, 16'h0000, 3'd7, 1'b1, 16'h1234, 16'h1234};
    vecs[7] = '{16'h1234, 16'h1234, 3'd1, 1'b0, 16'h1234, 16'h0000};
    vecs[8] = '{16'h0000, 16'h0001, 3'd1, 1'b0, 16'h0000, 16'hFFFF};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst res_valid", res_valid, 0);
    check("rst busy", busy, 0);
    check("rst alu_a", alu_a, 0);
    check("rst alu_b", alu_b, 0);
    check("rst alu_sel", alu_sel, 0);
    check("rst res_data", res_data, 0);
    check("rst3 res_valid", res_valid3, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst cmd_ready", cmd_ready, 1);
    check("post-rst cmd_ready3", cmd_ready3, 1);

    for (int i = 0; i < NVEC; i++) run1(vecs[i], i);

    // Backpressure: result must hold while res_ready is low and new commands are ignored.
    res_ready = 1'b0;
    @(negedge clk);
    cmd_a = 16'h0AB0; cmd_b = 16'h01AC; cmd_sel = 3'd1; cmd_chain = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d res_valid", k), res_valid, 1);
      check($sformatf("bp%0d res_data", k), res_data, 16'h0904);
      check($sformatf("bp%0d cmd_ready", k), cmd_ready, 0);
      cmd_a = 16'h7777; cmd_b = 16'h3333; cmd_sel = 3'd0; cmd_valid = k[0];
      @(negedge clk);
      check($sformatf("bp%0d alu_a_held", k), alu_a, 16'h0AB0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("bp handshake res_valid", res_valid, 0);
    check("bp handshake cmd_ready", cmd_ready, 1);
    check("bp alu_b not replaced", alu_b, 16'h01AC);
    check("bp alu_sel not replaced", alu_sel, 1);

    // Settle: SETTLE=3 instance captures on the third edge after accept.
    @(negedge clk);
    cmd_a3 = 16'h0001; cmd_b3 = 16'h0002; cmd_sel3 = 3'd0; cmd_chain3 = 1'b0; cmd_valid3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("st%0d res_valid3", k), res_valid3, 0);
      check($sformatf("st%0d busy3", k), busy3, 1);
      check($sformatf("st%0d alu_a3", k), alu_a3, 16'h0001);
      check($sformatf("st%0d alu_b3", k), alu_b3, 16'h0002);
      check($sformatf("st%0d alu_sel3", k), alu_sel3, 0);
      @(negedge clk);
    end
    check("st res_valid3", res_valid3, 1);
    check("st res_data3", res_data3, 16'h0003);
    check("st alu_a3 held", alu_a3, 16'h0001);
    @(negedge clk);
    check("st res_valid3 drop", res_valid3, 0);
    check("st cmd_ready3", cmd_ready3, 1);
    check("st alu_b3 after", alu_b3, 16'h0002);

    // Reset mid-ISSUE discards the in-flight result and clears the accumulator.
    @(negedge clk);
    cmd_a = 16'h1111; cmd_b = 16'h2222; cmd_sel = 3'd0; cmd_chain = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rm busy in issue", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rm res_valid", res_valid, 0);
    check("rm busy", busy, 0);
    check("rm alu_a", alu_a, 0);
    check("rm alu_b", alu_b, 0);
    check("rm alu_sel", alu_sel, 0);
    check("rm res_data", res_data, 0);
`ifdef ALU_SEQ_FLAGS_EN
    check("rm res_zero", res_zero, 0);
    check("rm res_neg", res_neg, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("rm res_valid after", res_valid, 0);
    check("rm cmd_ready after", cmd_ready, 1);
    run1('{16'hDEAD, 16'h0005, 3'd0, 1'b1, 16'h0000, 16'h0005}, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
